// File: rtl/ppu_tile_scheduler.sv
// Round-robin scheduler sharing one post-processing unit among several tile banks.
// Grants a requester, streams its partial-sum beats to the PPU, and returns the tagged result.
module ppu_tile_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned BEATS   = 16,
    parameter int unsigned PSUM_W  = 384,
    parameter int unsigned OUT_W   = 128,
    parameter int unsigned TIMEOUT = 255,
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*8-1:0]   req_scale,
    input  logic [NUM_REQ*8-1:0]   req_bias,
    output logic [NUM_REQ-1:0]     grant,
    input  logic [PSUM_W-1:0]      src_psum,
    input  logic                   src_valid,
    output logic                   src_ready,
    output logic [PSUM_W-1:0]      ppu_partial_sum,
    output logic [7:0]             ppu_scale,
    output logic [7:0]             ppu_bias,
    output logic                   ppu_valid,
    input  logic                   ppu_done,
    input  logic [OUT_W-1:0]       ppu_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [OUT_W-1:0]       rsp_data,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam int unsigned BCNT_W = $clog2(BEATS + 1);
    localparam int unsigned WCNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CONFIG    = 3'd1,
        S_STREAM    = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RESPOND   = 3'd4
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [BCNT_W-1:0]   beat_cnt;
    logic [WCNT_W-1:0]   wait_cnt;

    logic [ID_W-1:0]     pick_id;
    logic                pick_found;
    int unsigned         idx;

    // First active request at or after the round-robin pointer, wrapping.
    always_comb begin
        pick_id    = '0;
        pick_found = 1'b0;
        idx        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!pick_found && req[ID_W'(idx)]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            rr_ptr          <= '0;
            beat_cnt        <= '0;
            wait_cnt        <= '0;
            grant           <= '0;
            src_ready       <= 1'b0;
            ppu_partial_sum <= '0;
            ppu_scale       <= '0;
            ppu_bias        <= '0;
            ppu_valid       <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_id          <= '0;
            rsp_data        <= '0;
            rsp_err         <= 1'b0;
            busy            <= 1'b0;
        end else begin
            ppu_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant     <= NUM_REQ'(1) << pick_id;
                        rsp_id    <= pick_id;
                        ppu_scale <= req_scale[32'(pick_id)*8 +: 8];
                        ppu_bias  <= req_bias[32'(pick_id)*8 +: 8];
                        busy      <= 1'b1;
                        state     <= S_CONFIG;
                    end
                end
                S_CONFIG: begin
                    src_ready <= 1'b1;
                    beat_cnt  <= '0;
                    state     <= S_STREAM;
                end
                S_STREAM: begin
                    if (src_valid && src_ready) begin
                        ppu_partial_sum <= src_psum;
                        ppu_valid       <= 1'b1;
                        if (beat_cnt == BCNT_W'(BEATS - 1)) begin
                            src_ready <= 1'b0;
                            beat_cnt  <= '0;
                            wait_cnt  <= '0;
                            state     <= S_WAIT_DONE;
                        end else begin
                            beat_cnt <= beat_cnt + BCNT_W'(1);
                        end
                    end
                end
                // A done pulse on the final timeout cycle still delivers real data.
                S_WAIT_DONE: begin
                    if (ppu_done) begin
                        rsp_data  <= ppu_data;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESPOND;
                    end else if (wait_cnt == WCNT_W'(TIMEOUT)) begin
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= S_RESPOND;
                    end else begin
                        wait_cnt <= wait_cnt + WCNT_W'(1);
                    end
                end
                S_RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        grant     <= '0;
                        busy      <= 1'b0;
                        rr_ptr    <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + ID_W'(1);
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_tile_scheduler.sv
// Directed bench for ppu_tile_scheduler: arbitration order, beat streaming, timeout, stall and reset abort.
module tb_ppu_tile_scheduler;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned BEATS   = 16;
    localparam int unsigned PSUM_W  = 384;
    localparam int unsigned OUT_W   = 128;
    localparam int unsigned TIMEOUT = 255;
    localparam int unsigned ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_scale, req_bias;
    logic [NUM_REQ-1:0]   grant;
    logic [PSUM_W-1:0]    src_psum;
    logic                 src_valid, src_ready;
    logic [PSUM_W-1:0]    ppu_partial_sum;
    logic [7:0]           ppu_scale, ppu_bias;
    logic                 ppu_valid, ppu_done;
    logic [OUT_W-1:0]     ppu_data;
    logic                 rsp_valid, rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [OUT_W-1:0]     rsp_data;
    logic                 rsp_err, busy;

    int errors = 0;
    int checks = 0;

    ppu_tile_scheduler #(
        .NUM_REQ(NUM_REQ), .BEATS(BEATS), .PSUM_W(PSUM_W), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_scale(req_scale), .req_bias(req_bias),
        .grant(grant), .src_psum(src_psum), .src_valid(src_valid), .src_ready(src_ready),
        .ppu_partial_sum(ppu_partial_sum), .ppu_scale(ppu_scale), .ppu_bias(ppu_bias),
        .ppu_valid(ppu_valid), .ppu_done(ppu_done), .ppu_data(ppu_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Observers: forwarded beats, accept-to-strobe latency, grant exclusivity.
    logic [PSUM_W-1:0] pv_q[$];
    int  lat_err = 0;
    int  overlap_cnt = 0;
    bit  prev_acc = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_acc = 1'b0;
        end else begin
            if (ppu_valid) pv_q.push_back(ppu_partial_sum);
            if (ppu_valid !== prev_acc) lat_err++;
            if ($countones(grant) > 1) overlap_cnt++;
            prev_acc = src_valid && src_ready;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drive_beats(input int n, input bit gaps, input logic [PSUM_W-1:0] base, output bit ok);
        int sent = 0;
        int cyc = 0;
        bit t = 1'b1;
        bit acc;
        src_valid = 1'b1;
        src_psum  = base;
        while (sent < n && cyc < 400) begin
            @(negedge clk);
            acc = src_valid && src_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) sent++;
            t = gaps ? ~t : 1'b1;
            src_valid = (sent < n) ? t : 1'b0;
            src_psum  = base + PSUM_W'(sent);
        end
        src_valid = 1'b0;
        ok = (sent == n);
    endtask

    task automatic run_tile(input logic [NUM_REQ-1:0] req_v, input bit hold, input bit gaps,
                            input int done_dly, input logic [OUT_W-1:0] dval,
                            input logic [PSUM_W-1:0] base, input bit ack,
                            output logic [NUM_REQ-1:0] g, output logic [ID_W-1:0] rid,
                            output logic [OUT_W-1:0] rdata, output logic rerr,
                            output int wcyc, output bit ok);
        bit bok;
        int c = 0;
        ok = 1'b1;
        pv_q.delete();
        req = req_v;
        @(negedge clk);
        while (grant == '0 && c < 20) begin
            c++;
            @(negedge clk);
        end
        g = grant;
        if (g == '0) ok = 1'b0;
        if (!hold) req = '0;
        drive_beats(BEATS, gaps, base, bok);
        if (!bok) ok = 1'b0;
        if (done_dly > 0) begin
            repeat (done_dly - 1) @(posedge clk);
            #1;
            ppu_done = 1'b1;
            ppu_data = dval;
            @(posedge clk);
            #1 ppu_done = 1'b0;
        end
        wcyc = 0;
        @(negedge clk);
        while (!rsp_valid && wcyc < 400) begin
            wcyc++;
            @(negedge clk);
        end
        if (!rsp_valid) ok = 1'b0;
        rid   = rsp_id;
        rdata = rsp_data;
        rerr  = rsp_err;
        if (ack) begin
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({grant, src_ready, ppu_valid, busy} !== '0) begin errors++; $display("FAIL reset_ctrl: got %b exp 0", {grant, src_ready, ppu_valid, busy}); end
        checks++; if ({ppu_partial_sum, ppu_scale, ppu_bias} !== '0) begin errors++; $display("FAIL reset_ppu: got %0h exp 0", {ppu_scale, ppu_bias}); end
        checks++; if ({rsp_valid, rsp_id, rsp_data, rsp_err} !== '0) begin errors++; $display("FAIL reset_rsp: got v=%b id=%0d err=%b exp 0", rsp_valid, rsp_id, rsp_err); end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [NUM_REQ-1:0] g; logic [ID_W-1:0] rid; logic [OUT_W-1:0] rdata; logic rerr;
        int wcyc; bit ok; int bad = 0;
        logic [PSUM_W-1:0] base = {12{32'hA0A0_0000}};
        logic [OUT_W-1:0] dval = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        run_tile(4'b0100, 1'b0, 1'b0, 10, dval, base, 1'b0, g, rid, rdata, rerr, wcyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_flow: tile did not complete"); end
        checks++; if (g !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b exp 0100", g); end
        checks++; if (ppu_scale !== 8'd3 || ppu_bias !== 8'd5) begin errors++; $display("FAIL single_cfg: got scale=%0d bias=%0d exp 3/5", ppu_scale, ppu_bias); end
        checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL single_ready_drop: got %b exp 0", src_ready); end
        checks++; if (pv_q.size() != BEATS) begin errors++; $display("FAIL single_strobes: got %0d exp %0d", pv_q.size(), BEATS); end
        for (int i = 0; i < pv_q.size(); i++) if (pv_q[i] !== base + PSUM_W'(i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL single_data_order: got %0d bad beats exp 0", bad); end
        checks++; if (rid !== 2'd2 || rerr !== 1'b0) begin errors++; $display("FAIL single_rsp_id: got id=%0d err=%b exp 2/0", rid, rerr); end
        checks++; if (rdata !== dval) begin errors++; $display("FAIL single_rsp_data: got %h exp %h", rdata, dval); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if ({rsp_valid, busy, grant} !== '0) begin errors++; $display("FAIL single_release: got %b exp 0", {rsp_valid, busy, grant}); end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] g; logic [ID_W-1:0] rid; logic [OUT_W-1:0] rdata; logic rerr;
        int wcyc; bit ok;
        int exp_id;
        apply_reset();
        overlap_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            exp_id = i % 4;
            run_tile(4'b1111, 1'b1, 1'b0, 3, OUT_W'(i + 100), {12{32'hB0B0_0000}}, 1'b1, g, rid, rdata, rerr, wcyc, ok);
            checks++; if (!ok || g !== 4'(1 << exp_id) || rid !== 2'(exp_id)) begin errors++; $display("FAIL rr_grant_%0d: got grant=%b id=%0d exp id %0d", i, g, rid, exp_id); end
        end
        req = '0;
        checks++; if (overlap_cnt != 0) begin errors++; $display("FAIL rr_onehot: got %0d overlaps exp 0", overlap_cnt); end
    endtask

    task automatic test_gaps();
        logic [NUM_REQ-1:0] g; logic [ID_W-1:0] rid; logic [OUT_W-1:0] rdata; logic rerr;
        int wcyc; bit ok; int bad = 0;
        logic [PSUM_W-1:0] base = {12{32'hC0C0_0000}};
        lat_err = 0;
        run_tile(4'b0010, 1'b0, 1'b1, 6, 128'hC0FFEE, base, 1'b1, g, rid, rdata, rerr, wcyc, ok);
        checks++; if (!ok || rid !== 2'd1) begin errors++; $display("FAIL gaps_flow: ok=%b id=%0d exp 1", ok, rid); end
        checks++; if (pv_q.size() != BEATS) begin errors++; $display("FAIL gaps_strobes: got %0d exp %0d", pv_q.size(), BEATS); end
        for (int i = 0; i < pv_q.size(); i++) if (pv_q[i] !== base + PSUM_W'(i)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL gaps_data_order: got %0d bad beats exp 0", bad); end
        checks++; if (lat_err != 0) begin errors++; $display("FAIL gaps_latency: got %0d mis-timed strobes exp 0", lat_err); end
    endtask

    task automatic test_timeout();
        logic [NUM_REQ-1:0] g; logic [ID_W-1:0] rid; logic [OUT_W-1:0] rdata; logic rerr;
        int wcyc; bit ok;
        run_tile(4'b1000, 1'b0, 1'b0, 0, '0, {12{32'hD0D0_0000}}, 1'b1, g, rid, rdata, rerr, wcyc, ok);
        checks++; if (!ok || rid !== 2'd3) begin errors++; $display("FAIL timeout_flow: ok=%b id=%0d exp 3", ok, rid); end
        checks++; if (rerr !== 1'b1 || rdata !== '0) begin errors++; $display("FAIL timeout_rsp: got err=%b data=%h exp 1/0", rerr, rdata); end
        checks++; if (wcyc < 255 || wcyc > 256) begin errors++; $display("FAIL timeout_cycles: got %0d exp 255..256", wcyc); end
        run_tile(4'b0001, 1'b0, 1'b0, 5, 128'hBEEF, {12{32'hD1D1_0000}}, 1'b1, g, rid, rdata, rerr, wcyc, ok);
        checks++; if (!ok || rid !== 2'd0 || rerr !== 1'b0 || rdata !== 128'hBEEF) begin errors++; $display("FAIL timeout_recover: got id=%0d err=%b data=%h exp 0/0/beef", rid, rerr, rdata); end
    endtask

    task automatic test_rsp_stall();
        logic [NUM_REQ-1:0] g; logic [ID_W-1:0] rid; logic [OUT_W-1:0] rdata; logic rerr;
        int wcyc; bit ok; int bad = 0;
        run_tile(4'b0100, 1'b1, 1'b0, 2, 128'h5A5A, {12{32'hE0E0_0000}}, 1'b0, g, rid, rdata, rerr, wcyc, ok);
        checks++; if (!ok || rid !== 2'd2 || rdata !== 128'h5A5A) begin errors++; $display("FAIL stall_rsp: got id=%0d data=%h exp 2/5a5a", rid, rdata); end
        req = 4'b1111;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin ppu_done = 1'b1; ppu_data = 128'hDEAD; end
            if (i == 6) ppu_done = 1'b0;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 128'h5A5A ||
                grant !== 4'b0100 || src_ready !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles exp 0", bad); end
        req = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || grant !== '0) begin errors++; $display("FAIL stall_release: got v=%b grant=%b exp 0", rsp_valid, grant); end
    endtask

    task automatic test_reset_mid();
        logic [NUM_REQ-1:0] g; logic [ID_W-1:0] rid; logic [OUT_W-1:0] rdata; logic rerr;
        int wcyc; bit ok; bit bok; int c = 0;
        logic [PSUM_W-1:0] base = {12{32'hF0F0_0000}};
        req = 4'b0010;
        @(negedge clk);
        while (grant == '0 && c < 20) begin c++; @(negedge clk); end
        drive_beats(7, 1'b0, base, bok);
        checks++; if (!bok || ppu_valid !== 1'b1) begin errors++; $display("FAIL abort_setup: ok=%b ppu_valid=%b exp 1/1", bok, ppu_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if ({grant, src_ready, ppu_valid, busy, rsp_valid, ppu_scale, ppu_bias} !== '0 || ppu_partial_sum !== '0) begin
            errors++; $display("FAIL abort_outputs: got %b exp 0", {grant, src_ready, ppu_valid, busy, rsp_valid});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_tile(4'b0010, 1'b0, 1'b0, 4, 128'h77, base, 1'b1, g, rid, rdata, rerr, wcyc, ok);
        checks++; if (!ok || rid !== 2'd1 || rdata !== 128'h77 || rerr !== 1'b0) begin errors++; $display("FAIL abort_restart: got id=%0d data=%h err=%b exp 1/77/0", rid, rdata, rerr); end
        checks++; if (pv_q.size() != BEATS || pv_q[0] !== base) begin errors++; $display("FAIL abort_from_beat0: got %0d strobes exp %0d from beat 0", pv_q.size(), BEATS); end
    endtask

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        req_scale = {8'd9, 8'd3, 8'd7, 8'd1};
        req_bias  = {8'd8, 8'd5, 8'd6, 8'd2};
        src_psum  = '0;
        src_valid = 1'b0;
        ppu_done  = 1'b0;
        ppu_data  = '0;
        rsp_ready = 1'b0;

        test_reset();
        test_single();
        test_round_robin();
        test_gaps();
        test_timeout();
        test_rsp_stall();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
